data_mem_sync: RTL and testbench

Parametrised successor to the team's single-cycle data memory. Multi-lane write masking, registered read with a valid pulse, out-of-range detection, and a hardware clear sequencer that zeroes the array one word per cycle after reset or on request. It sits on the CPU datapath's load/store path. The `ready` output tells the control unit when requests are accepted.

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/data_mem_array.sv | 37 +++
 rtl/data_mem_sync.sv | 133 +++++++++++++
 tb/tb_data_mem_sync.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data_mem_sync block:
// FSM state encoding, lane-count helper and the all-zero word.
package data_mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } mem_state_t;

    // Widest word any instance may use; narrower instances slice ZERO_WORD.
    localparam int MAX_DATA_W = 1024;
    localparam logic [MAX_DATA_W-1:0] ZERO_WORD = {MAX_DATA_W{1'b0}};

    function automatic int lanes_of(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Storage only: DEPTH x DATA_W words, one lane-masked write port and one
// asynchronous read port. Contents are deliberately not reset.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                                 clk,
    input  logic                                 we,
    input  logic [IDX_W-1:0]                     waddr,
    input  logic [DATA_W-1:0]                    wdata,
    input  logic [lanes_of(DATA_W, LANE_W)-1:0]  wmask,
    input  logic [IDX_W-1:0]                     raddr,
    output logic [DATA_W-1:0]                    rdata
);

    localparam int LANES = lanes_of(DATA_W, LANE_W);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Lane-masked word write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem_r[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem_sync.sv
// Data memory with lane-masked writes, registered reads, range checking and a
// one-word-per-cycle clear sequencer that runs after reset or on request.
module data_mem_sync
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    input  logic                                 req_write,
    input  logic [ADDR_W-1:0]                    address,
    input  logic [DATA_W-1:0]                    writeData,
    input  logic [lanes_of(DATA_W, LANE_W)-1:0]  wmask,
    input  logic                                 clr_req,
    output logic                                 ready,
    output logic [DATA_W-1:0]                    readData,
    output logic                                 rvalid,
    output logic                                 addr_err
);

    localparam int LANES = lanes_of(DATA_W, LANE_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] ZERO_DATA = ZERO_WORD[DATA_W-1:0];
    // One extra bit so DEPTH == 2**ADDR_W does not truncate to zero.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    if (DATA_W % LANE_W != 0) begin : g_chk_lane
        $error("data_mem_sync: DATA_W must be a multiple of LANE_W");
    end
    if ((DEPTH < 2) || (64'(DEPTH) > (64'd1 << ADDR_W))) begin : g_chk_depth
        $error("data_mem_sync: DEPTH must lie in [2, 2**ADDR_W]");
    end

    mem_state_t         state_r;
    logic [ADDR_W-1:0]  clr_ptr_r;

    logic               accept_s;
    logic               in_range_s;
    logic               arr_we_s;
    logic [IDX_W-1:0]   arr_waddr_s;
    logic [DATA_W-1:0]  arr_wdata_s;
    logic [LANES-1:0]   arr_wmask_s;
    logic [IDX_W-1:0]   arr_raddr_s;
    logic [DATA_W-1:0]  arr_rdata_s;

    assign ready       = (state_r == ST_IDLE);
    assign accept_s    = req_valid && ready;
    assign in_range_s  = ({1'b0, address} < DEPTH_EXT);
    assign arr_raddr_s = in_range_s ? address[IDX_W-1:0] : {IDX_W{1'b0}};

    // Write-port mux: the clear sequencer owns the port while clearing
    always_comb begin
        arr_we_s    = 1'b0;
        arr_waddr_s = {IDX_W{1'b0}};
        arr_wdata_s = ZERO_DATA;
        arr_wmask_s = {LANES{1'b0}};
        if (state_r == ST_CLEAR) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = clr_ptr_r[IDX_W-1:0];
            arr_wmask_s = {LANES{1'b1}};
        end else if (accept_s && req_write && in_range_s) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = address[IDX_W-1:0];
            arr_wdata_s = writeData;
            arr_wmask_s = wmask;
        end else begin
            arr_we_s    = 1'b0;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .waddr (arr_waddr_s),
        .wdata (arr_wdata_s),
        .wmask (arr_wmask_s),
        .raddr (arr_raddr_s),
        .rdata (arr_rdata_s)
    );

    // FSM, clear pointer and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {ADDR_W{1'b0}};
            readData  <= ZERO_DATA;
            rvalid    <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    if (clr_ptr_r == LAST_PTR) begin
                        state_r   <= ST_IDLE;
                        clr_ptr_r <= {ADDR_W{1'b0}};
                    end else begin
                        clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_err <= !in_range_s;
                        if (!req_write) begin
                            readData <= in_range_s ? arr_rdata_s : ZERO_DATA;
                            rvalid   <= 1'b1;
                        end
                    end
                    // A request accepted on this edge still completes above.
                    if (clr_req) begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= {ADDR_W{1'b0}};
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_sync.sv
// Randomised scoreboard bench for data_mem_sync: the driver updates a
// word-array reference model and queues expected responses per edge.
module tb_data_mem_sync;

    localparam int DATA_W = 32;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic [3:0]        wmask;
    logic              clr_req;
    logic              ready;
    logic [DATA_W-1:0] readData;
    logic              rvalid;
    logic              addr_err;

    data_mem_sync #(
        .DATA_W (DATA_W), .LANE_W (LANE_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .address   (address),
        .writeData (writeData),
        .wmask     (wmask),
        .clr_req   (clr_req),
        .ready     (ready),
        .readData  (readData),
        .rvalid    (rvalid),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rv;
        bit          err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata = 32'd0;
    int          m_busy  = DEPTH;
    bit          m_ready = 1'b0;
    int          mcyc    = 0;
    int          total   = 0;
    int          bad     = 0;

    // One clock cycle of stimulus; the reference model advances at the edge.
    task automatic cycle(input bit v, input bit w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         input bit c, input bit r);
        exp_t e;
        logic [31:0] rd;
        req_valid = v; req_write = w; address = a; writeData = d;
        wmask = m; clr_req = c; rst = r;
        @(posedge clk);
        mcyc++;
        if (r) begin
            m_busy  = DEPTH;
            m_rdata = 32'd0;
            sb.delete();
        end else if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (v) begin
                if (w) begin
                    if (a < DEPTH) begin
                        for (int i = 0; i < 4; i++)
                            if (m[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
                    end else begin
                        e.rv = 1'b0; e.err = 1'b1; e.data = 32'd0; e.due = mcyc;
                        sb.push_back(e);
                    end
                end else begin
                    rd = (a < DEPTH) ? m_mem[a] : 32'd0;
                    m_rdata = rd;
                    e.rv = 1'b1; e.err = (a >= DEPTH); e.data = rd; e.due = mcyc;
                    sb.push_back(e);
                end
            end
            if (c) begin
                m_busy = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
            end
        end
        m_ready = (m_busy == 0) && !r;
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a);
        cycle(1'b1, 1'b0, a, 32'd0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        cycle(1'b1, 1'b1, a, d, m, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    endtask

    // Monitor: checks ready/readData every cycle and pops due responses.
    always @(negedge clk) begin
        exp_t e;
        total++;
        if (ready !== m_ready) begin
            bad++;
            $display("FAIL ready @%0d: got %b want %b", mcyc, ready, m_ready);
        end
        total++;
        if (readData !== m_rdata) begin
            bad++;
            $display("FAIL readData_hold @%0d: got %h want %h", mcyc, readData, m_rdata);
        end
        total++;
        if (sb.size() > 0 && sb[0].due == mcyc) begin
            e = sb.pop_front();
            if (rvalid !== e.rv || addr_err !== e.err || (e.rv && readData !== e.data)) begin
                bad++;
                $display("FAIL response @%0d: got rv=%b err=%b data=%h want rv=%b err=%b data=%h",
                         mcyc, rvalid, addr_err, readData, e.rv, e.err, e.data);
            end
        end else if (rvalid !== 1'b0 || addr_err !== 1'b0) begin
            bad++;
            $display("FAIL spurious @%0d: got rv=%b err=%b want rv=0 err=0",
                     mcyc, rvalid, addr_err);
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        // Reset, then release with a read request held high throughout the clear
        cycle(1'b1, 1'b0, 5'd2, 32'd0, 4'h0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 5'd2, 32'd0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 5'(i), 32'd0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) rd(5'(i));

        // Masked write merge
        wr(5'd3, 32'hAABBCCDD, 4'hF);
        wr(5'd3, 32'h11223344, 4'b0101);
        rd(5'd3);
        wr(5'd4, 32'hDEADBEEF, 4'h0);
        rd(5'd4);

        // Out of range
        wr(5'd5, 32'h55AA55AA, 4'hF);
        rd(5'd25);
        wr(5'd25, 32'hFFFFFFFF, 4'hF);
        rd(5'd5);

        // Clear with a simultaneous write
        cycle(1'b1, 1'b1, 5'd7, 32'h12345678, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) rd(5'd7);
        rd(5'd7);
        rd(5'd3);

        // Reset at clear step 10
        wr(5'd15, 32'hCAFEF00D, 4'hF);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 1'b0);
        idle(10);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) rd(5'd15);
        rd(5'd15);

        // Throughput: preload then 8 back-to-back reads
        for (int i = 0; i < 8; i++) wr(5'(i), 32'(i) * 32'h01010101, 4'hF);
        for (int i = 0; i < 8; i++) rd(5'(i));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 63) == 0, 1'b0);
        end
        idle(2);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
